fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch (IF) stage of the 64-bit RV64I five-stage pipelined processor. It owns the program counter and drives `inst_addr` to the combinational instruction memory. It captures the returned 32-bit word into the IF/ID pipeline register. It honours stall requests from the hazard unit and branch redirects/flushes from the branch-resolution stage, and halts fetch cleanly when the PC leaves the populated instruction memory.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
IMEM_BYTES, 168, size of the instruction memory in bytes; last valid fetch address is IMEM_BYTES-4.
NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) injected on flush or halt.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hazard unit: hold PC and IF/ID this cycle.
branch_taken  input  1  redirect request; flushes IF/ID.
branch_target  input  64  redirect address.
inst_addr  output  64  byte address to instruction memory (combinational).
inst  input  32  instruction word from memory, valid in the same cycle as inst_addr.
ifid_pc  output  64  PC of the instruction held in IF/ID.
ifid_inst  output  32  instruction held in IF/ID.
ifid_valid  output  1  IF/ID holds a real fetched instruction.
halted  output  1  fetch has stopped at end of memory.
fetch_count  output  32  count of instructions fetched into IF/ID.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All state updates occur on the rising edge.
- Reset values:
  - pc = RESET_PC; state = RUN.
  - ifid_pc = 0; ifid_inst = NOP_INST; ifid_valid = 0.
  - halted = 0; fetch_count = 0.
- `in_range` (combinational) = (pc <= IMEM_BYTES-4) && (pc[1:0] == 0).
- inst_addr = in_range ? pc : 0. This never presents an out-of-range address to memory.
- States are RUN and HALTED. halted = (state == HALTED) and is registered.
- Per-cycle priority: reset > branch_taken > stall > HALTED hold > RUN fetch.
- branch_taken (in any state, stall ignored):
  - pc <= {branch_target[63:2], 2'b00}. A misaligned target is force-aligned.
  - IF/ID <= {pc, NOP_INST, valid=0}.
  - state <= RUN. A branch exits HALTED.
  - fetch_count holds.
- stall (no branch): pc, IF/ID, state, and fetch_count all hold.
- RUN, in_range, no stall/branch:
  - IF/ID <= {pc, inst, 1}.
  - pc <= pc + 4.
  - fetch_count <= fetch_count + 1. Wraps modulo 2^32.
- RUN, !in_range, no stall/branch:
  - state <= HALTED.
  - IF/ID <= {pc, NOP_INST, 0}.
  - pc and fetch_count hold.
- HALTED, no branch: pc holds; IF/ID <= {ifid_pc, NOP_INST, 0}; fetch_count holds.
- Latency: an instruction at address A appears on ifid_inst one cycle after pc == A, absent stall or branch.
- A branch to an out-of-range target costs one bubble, then HALTED on the following cycle.
- Reset mid-stall, mid-branch, or while HALTED returns to the reset values on the next edge.

Decomposition:
- Shared package/header `riscv_defs`: NOP_INST, RESET_PC, the RUN/HALTED state encoding, and XLEN=64.
- Natural sub-module: `ifid_reg`. It is the IF/ID pipeline register with hold (stall) and flush (load NOP, valid=0) controls, and is reusable for the other pipeline registers.
- PC/state/counter logic stays in fetch_stage.

Test Plan:
- Sequential fetch: reset then 3 free cycles → ifid_inst sequence 0x00000013, 0x00900413, 0x00000493; ifid_pc 0x0, 0x4, 0x8; fetch_count = 3; inst_addr = 0xC.
- Stall: assert stall for 2 cycles while pc = 0xC → pc, ifid_inst (0x00000493), and fetch_count unchanged. Release stall → next ifid_pc = 0xC.
- Redirect, and redirect versus stall: branch_taken with target 0x60 → next cycle ifid_valid = 0, ifid_inst = 0x13, pc = 0x60; following cycle ifid_inst = 0x04890263. Repeat with stall=1 in the same cycle → identical result (branch wins).
- Misaligned target 0x62 → pc = 0x60, fetch proceeds normally.
- End of memory: free-run from reset →
  - at pc = 0xA4, ifid_inst = 0x00000013 with valid = 1;
  - at pc = 0xA8, halted = 1 next cycle, fetch_count = 42, inst_addr = 0, ifid_valid stays 0 indefinitely.
- Exit halt and reset: while halted, branch_taken with target 0x0 → halted = 0 next cycle, fetch resumes at 0x0. Assert reset while halted → all outputs return to reset values after one edge.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared RV64I pipeline definitions: widths, bubble encoding, fetch states.
package riscv_defs;

  localparam int XLEN = 64;

  localparam logic [31:0]     NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // One IF/ID pipeline register entry
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: hold keeps contents, flush loads a bubble
// (pc passes through so the bubble still carries a meaningful address).
module ifid_reg
  import riscv_defs::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hold,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  // Flush outranks hold so a redirect always clears the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      q.pc    <= '0;
      q.inst  <= NOP_INST;
      q.valid <= 1'b0;
    end else if (flush) begin
      q.pc    <= d.pc;
      q.inst  <= NOP_INST;
      q.valid <= 1'b0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV64I instruction-fetch stage: PC, run/halt FSM, fetch counter, IF/ID reg.
module fetch_stage
  import riscv_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC_P = RESET_PC,
  parameter int              IMEM_BYTES = 168
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] inst_addr,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_inst,
  output logic            ifid_valid,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  localparam logic [XLEN-1:0] LAST_ADDR = XLEN'(IMEM_BYTES - 4);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [31:0]     cnt_next;
  logic            in_range;
  logic            ifid_hold, ifid_flush;
  ifid_t           ifid_d, ifid_q;

  assign in_range  = (pc <= LAST_ADDR) && (pc[1:0] == 2'b00);
  // Memory never sees an address outside the populated range
  assign inst_addr = in_range ? pc : '0;

  // State, PC and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC_P;
      fetch_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      fetch_count <= cnt_next;
    end
  end

  // Next-state and IF/ID control: branch > stall > halted hold > run fetch
  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = fetch_count;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    ifid_d     = '{pc: pc, inst: inst, valid: 1'b1};
    if (branch_taken) begin
      state_next = ST_RUN;
      pc_next    = branch_target & ~XLEN'(3);  // force word alignment
      ifid_flush = 1'b1;
    end else if (stall) begin
      ifid_hold = 1'b1;
    end else if (state == ST_HALTED) begin
      // keep re-presenting the last PC as a bubble
      ifid_flush = 1'b1;
      ifid_d.pc  = ifid_q.pc;
    end else if (!in_range) begin
      state_next = ST_HALTED;
      ifid_flush = 1'b1;
    end else begin
      pc_next  = pc + XLEN'(4);
      cnt_next = fetch_count + 32'd1;
    end
  end

  ifid_reg u_ifid (
    .clk   (clk),
    .reset (reset),
    .hold  (ifid_hold),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign ifid_pc    = ifid_q.pc;
  assign ifid_inst  = ifid_q.inst;
  assign ifid_valid = ifid_q.valid;
  assign halted     = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus end-of-memory/halt sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [63:0] branch_target, inst_addr, ifid_pc;
  logic [31:0] inst, ifid_inst, fetch_count;
  logic        ifid_valid, halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] imem [0:41];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .inst_addr(inst_addr), .inst(inst),
    .ifid_pc(ifid_pc), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  // Combinational instruction memory, 42 words
  always_comb begin
    inst = 32'hDEAD_BEEF;
    if ((inst_addr >> 2) < 64'd42) inst = imem[inst_addr[7:2]];
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [63:0] tgt;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_halted;
    logic [31:0] e_cnt;
    logic [63:0] e_addr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [63:0] pc_e, input logic [31:0] inst_e,
                           input logic v_e, input logic h_e, input logic [31:0] c_e,
                           input logic [63:0] a_e);
    chk({tag, ".ifid_pc"},     ifid_pc,     pc_e);
    chk({tag, ".ifid_inst"},   64'(ifid_inst), 64'(inst_e));
    chk({tag, ".ifid_valid"},  64'(ifid_valid), 64'(v_e));
    chk({tag, ".halted"},      64'(halted), 64'(h_e));
    chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(c_e));
    chk({tag, ".inst_addr"},   inst_addr,   a_e);
  endtask

  // Apply inputs, take one rising edge, settle before sampling
  task automatic step(input logic s, input logic b, input logic [63:0] t);
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 64'h0);
    reset = 1'b0;
  endtask

  vec_t vecs [13];

  initial begin
    for (int i = 0; i < 42; i++) imem[i] = 32'h0A00_0000 | 32'(i * 4);
    imem[0]          = 32'h0000_0013;
    imem[1]          = 32'h0090_0413;
    imem[2]          = 32'h0000_0493;
    imem['h60 >> 2]  = 32'h0489_0263;
    imem['hA4 >> 2]  = 32'h0000_0013;

    //              stall br  tgt     e_pc    e_inst         v  h  cnt  addr
    vecs[0]  = '{1'b0, 1'b0, 64'h0,  64'h0,  32'h0000_0013, 1, 0, 1, 64'h4};
    vecs[1]  = '{1'b0, 1'b0, 64'h0,  64'h4,  32'h0090_0413, 1, 0, 2, 64'h8};
    vecs[2]  = '{1'b0, 1'b0, 64'h0,  64'h8,  32'h0000_0493, 1, 0, 3, 64'hC};
    vecs[3]  = '{1'b1, 1'b0, 64'h0,  64'h8,  32'h0000_0493, 1, 0, 3, 64'hC};
    vecs[4]  = '{1'b1, 1'b0, 64'h0,  64'h8,  32'h0000_0493, 1, 0, 3, 64'hC};
    vecs[5]  = '{1'b0, 1'b0, 64'h0,  64'hC,  32'h0A00_000C, 1, 0, 4, 64'h10};
    vecs[6]  = '{1'b0, 1'b1, 64'h60, 64'h10, 32'h0000_0013, 0, 0, 4, 64'h60};
    vecs[7]  = '{1'b0, 1'b0, 64'h0,  64'h60, 32'h0489_0263, 1, 0, 5, 64'h64};
    vecs[8]  = '{1'b1, 1'b1, 64'h60, 64'h64, 32'h0000_0013, 0, 0, 5, 64'h60};
    vecs[9]  = '{1'b0, 1'b0, 64'h0,  64'h60, 32'h0489_0263, 1, 0, 6, 64'h64};
    vecs[10] = '{1'b0, 1'b1, 64'h62, 64'h64, 32'h0000_0013, 0, 0, 6, 64'h60};
    vecs[11] = '{1'b0, 1'b0, 64'h0,  64'h60, 32'h0489_0263, 1, 0, 7, 64'h64};
    vecs[12] = '{1'b0, 1'b0, 64'h0,  64'h64, 32'h0A00_0064, 1, 0, 8, 64'h68};

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all("reset", 64'h0, 32'h13, 1'b0, 1'b0, 32'd0, 64'h0);

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].stall, vecs[i].br, vecs[i].tgt);
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_valid,
                vecs[i].e_halted, vecs[i].e_cnt, vecs[i].e_addr);
    end

    // Free run to end of memory: 42 fetches, last one at 0xA4
    do_reset();
    for (int i = 0; i < 42; i++) step(1'b0, 1'b0, 64'h0);
    check_all("last_fetch", 64'hA4, 32'h13, 1'b1, 1'b0, 32'd42, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    check_all("halt_entry", 64'hA8, 32'h13, 1'b0, 1'b1, 32'd42, 64'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0);
    check_all("halt_hold", 64'hA8, 32'h13, 1'b0, 1'b1, 32'd42, 64'h0);

    // Branch out of range from halt: one bubble, then halted again
    step(1'b0, 1'b1, 64'hB0);
    check_all("oor_bubble", 64'hA8, 32'h13, 1'b0, 1'b0, 32'd42, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    check_all("oor_halt", 64'hB0, 32'h13, 1'b0, 1'b1, 32'd42, 64'h0);

    // Exit halt via branch to 0
    step(1'b0, 1'b1, 64'h0);
    check_all("exit_halt", 64'hB0, 32'h13, 1'b0, 1'b0, 32'd42, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    check_all("resume", 64'h0, 32'h13, 1'b1, 1'b0, 32'd43, 64'h4);

    // Get halted again, then reset (with stall high) while halted
    step(1'b0, 1'b1, 64'hA8);
    step(1'b0, 1'b0, 64'h0);
    check_all("rehalt", 64'hA8, 32'h13, 1'b0, 1'b1, 32'd43, 64'h0);
    reset = 1'b1;
    step(1'b1, 1'b0, 64'h0);
    reset = 1'b0;
    check_all("reset_halted", 64'h0, 32'h13, 1'b0, 1'b0, 32'd0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
